alu_result_tracer: RTL and testbench
====================================

Name: alu_result_tracer

Overview:
- Synthesizable consumer of the processor's ALUResultOut stream, the receiving end of the result interface the processor drives.
- Timestamps each distinct ALU result with a cycle count and buffers it in a show-ahead FIFO.
- A host, debug port or bench drains the FIFO through a valid/read handshake.
- Sits beside MIPS_Processor at top level, tapping ALUResultOut without loading the datapath.

Parameters:
DATA_WIDTH, 32, width of captured ALU result
DEPTH, 16, FIFO entries; power of two, >= 2
CYCLE_WIDTH, 16, timestamp counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
alu_result_in  input  DATA_WIDTH  ALUResultOut from processor
sample_en  input  1  capture enable
clr  input  1  synchronous flush: empties FIFO, clears overflow, returns to IDLE
rd_en  input  1  pop request
rd_valid  output  1  head entry present (= !empty)
rd_data  output  DATA_WIDTH  head result
rd_cycle  output  CYCLE_WIDTH  head timestamp
full  output  1  count == DEPTH
count  output  $clog2(DEPTH+1)  occupancy
overflow  output  1  sticky, a capture was dropped

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high; ports are named clk and reset.
  - Reset values: rd_valid=0, rd_data=0, rd_cycle=0, full=0, count=0, overflow=0.
  - Reset also clears the cycle counter, last_value and the pointers, and sets state=IDLE.
  - Reset mid-operation discards all entries.
- Cycle counter:
  - Increments every clock while not in reset.
  - Wraps from 2^CYCLE_WIDTH-1 to 0.
  - Not cleared by clr.
- FSM:
  - IDLE: no sample taken yet.
  - RUN: capturing.
  - IDLE->RUN on the first cycle with sample_en=1; that sample is always captured.
  - RUN->IDLE only on clr or reset.
- Capture condition: state==RUN, sample_en=1, alu_result_in != last_value; or the IDLE->RUN first sample.
  - last_value updates on every capture.
- Push: entry {alu_result_in, counter value at that edge}.
  - Visible at the head after one clock: rd_valid rises the cycle after the capture edge when the FIFO was empty.
- Pop: rd_en && rd_valid advances the head at the edge. rd_en while empty is ignored, with no error.
- Full:
  - A capture with no simultaneous pop is dropped; overflow sets to 1 and stays set until reset or clr.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no overflow.
- Empty: push and rd_en in the same cycle performs the push only.
- clr in the same cycle as a push or pop: clr wins.
- Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately to distinguish full from empty.
- rd_data/rd_cycle are don't-care when rd_valid=0; the bench must not check them.

Optional Feature:
ALU_TRACE_TRIGGER_EN
- Defined:
  - Adds input trigger_value [DATA_WIDTH-1:0] and state ARMED.
  - Reset and clr enter ARMED instead of IDLE.
  - ARMED->RUN on the first cycle where sample_en=1 and alu_result_in==trigger_value; that matching value is captured as the first entry.
- Undefined: port and state absent; behaviour as above.

Decomposition:
- Package alu_trace_pkg:
  - state encoding constants (IDLE, RUN, ARMED)
  - default widths
  - entry typedef {data, cycle}
- One sub-module: trace_fifo.
  - Parameterized show-ahead synchronous FIFO.
  - Owns the pointers, count, full and the push/pop priority rules.
- The top level holds the FSM, cycle counter, change detection and overflow.

Test Plan:
1. Reset, then sample_en=1 with alu_result_in held at 0x00000005 for 4 cycles -> exactly one entry, rd_data=0x5, rd_cycle = counter at first sample edge, count=1.
2. Drive the sequence 1,1,2,2,3 with sample_en=1, then pop all -> rd_data reads 1,2,3 in order, timestamps strictly increasing, then rd_valid=0.
3. DEPTH=16: push 17 distinct values without reading -> full=1, count=16, overflow=1, and the 17th value is absent on drain.
4. FIFO full, then push and rd_en in the same cycle -> count stays 16, overflow stays 0, head advances by one.
5. With 5 entries present, assert reset for one cycle -> next cycle count=0, rd_valid=0, overflow=0; the next sample after reset is captured even if it equals the pre-reset last_value.
6. With ALU_TRACE_TRIGGER_EN defined and trigger_value=0x0000000A, drive 3,7,10,12 -> entries are 10 then 12 only.

Source files
------------

// File: rtl/alu_trace_pkg.sv
// Shared constants and types for the ALU result tracer.
// Optional macro ALU_TRACE_TRIGGER_EN selects the ARMED start state.
package alu_trace_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int DEPTH_DEF       = 16;
  localparam int CYCLE_WIDTH_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]  data;
    logic [CYCLE_WIDTH_DEF-1:0] cycle;
  } trace_entry_t;

  // State entered on reset and on clr.
  function automatic logic [1:0] start_state();
`ifdef ALU_TRACE_TRIGGER_EN
    return ST_ARMED;
`else
    return ST_IDLE;
`endif
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO; owns pointers, occupancy and push/pop priority.
// Head data reads as zero while empty.
module trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             valid_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Accept/drop decisions and next occupancy; a full FIFO takes a push only alongside a pop.
  always_comb begin
    pop_ok_s    = pop && valid_r;
    push_ok_s   = push && (!full_r || pop_ok_s);
    drop        = push && full_r && !pop_ok_s;
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and status flag registers.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      valid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clr && !reset) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = valid_r ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign valid = valid_r;
  assign full  = full_r;
  assign count = count_r;

endmodule

// File: rtl/alu_result_tracer.sv
// Timestamps each distinct ALUResultOut value and queues it for a host to drain.
// Macro ALU_TRACE_TRIGGER_EN adds trigger_value and the ARMED start state.
module alu_result_tracer
  import alu_trace_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int CYCLE_WIDTH = CYCLE_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      alu_result_in,
  input  logic                       sample_en,
  input  logic                       clr,
  input  logic                       rd_en,
`ifdef ALU_TRACE_TRIGGER_EN
  input  logic [DATA_WIDTH-1:0]      trigger_value,
`endif
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [CYCLE_WIDTH-1:0]     rd_cycle,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [CYCLE_WIDTH-1:0] cycle;
  } entry_t;

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic                   capture_s;
  logic                   drop_s;
  logic [DATA_WIDTH-1:0]  last_value_r;
  logic [CYCLE_WIDTH-1:0] cyc_r;
  logic                   overflow_r;
  entry_t                 push_entry_s;
  entry_t                 head_entry_s;

  // Capture decision and FSM next state; clr overrides any capture.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    if (clr) begin
      state_nxt_s = start_state();
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sample_en) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          capture_s = sample_en && (alu_result_in != last_value_r);
        end
`ifdef ALU_TRACE_TRIGGER_EN
        ST_ARMED: begin
          if (sample_en && (alu_result_in == trigger_value)) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
`endif
        default: state_nxt_s = start_state();
      endcase
    end
  end

  // FSM state, free-running timestamp and last captured value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= start_state();
      cyc_r        <= {CYCLE_WIDTH{1'b0}};
      last_value_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cyc_r   <= cyc_r + CYCLE_WIDTH'(1);
      if (capture_s) last_value_r <= alu_result_in;
    end
  end

  // Sticky overflow: set when a capture is refused by a full FIFO.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign push_entry_s = '{data: alu_result_in, cycle: cyc_r};

  trace_fifo #(
    .WIDTH (DATA_WIDTH + CYCLE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (capture_s),
    .din   (push_entry_s),
    .pop   (rd_en),
    .dout  (head_entry_s),
    .valid (rd_valid),
    .full  (full),
    .count (count),
    .drop  (drop_s)
  );

  assign rd_data  = head_entry_s.data;
  assign rd_cycle = head_entry_s.cycle;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_alu_result_tracer.sv
// Directed-vector bench for alu_result_tracer (DEPTH=16, 32-bit data, 16-bit timestamps).
module tb_alu_result_tracer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in;
  logic        sample_en;
  logic        clr;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [15:0] rd_cycle;
  logic        full;
  logic [4:0]  count;
  logic        overflow;
`ifdef ALU_TRACE_TRIGGER_EN
  logic [31:0] trigger_value;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc_m = 0;

  alu_result_tracer #(.DATA_WIDTH(32), .DEPTH(16), .CYCLE_WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_result_in (alu_result_in),
    .sample_en     (sample_en),
    .clr           (clr),
    .rd_en         (rd_en),
`ifdef ALU_TRACE_TRIGGER_EN
    .trigger_value (trigger_value),
`endif
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_cycle      (rd_cycle),
    .full          (full),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. cyc_m tracks the timestamp counter.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) cyc_m = 0;
    else cyc_m = cyc_m + 1;
  endtask

  initial begin
    int t0;
    int prev;
    reset = 1'b1; sample_en = 1'b0; clr = 1'b0; rd_en = 1'b0;
    alu_result_in = 32'h0;
`ifdef ALU_TRACE_TRIGGER_EN
    trigger_value = 32'h0000000A;
`endif
    tick();
    check_eq("rst_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("rst_data", {32'd0, rd_data}, 64'd0);
    check_eq("rst_cycle", {48'd0, rd_cycle}, 64'd0);
    check_eq("rst_full", {63'd0, full}, 64'd0);
    check_eq("rst_count", {59'd0, count}, 64'd0);
    check_eq("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b0;

`ifdef ALU_TRACE_TRIGGER_EN
    // Trigger: 3,7 ignored; 10 arms capture at ts 2; 12 captured at ts 3.
    sample_en = 1'b1;
    alu_result_in = 32'd3;  tick();
    alu_result_in = 32'd7;  tick();
    check_eq("trg_wait_count", {59'd0, count}, 64'd0);
    alu_result_in = 32'd10; tick();
    alu_result_in = 32'd12; tick();
    sample_en = 1'b0;
    check_eq("trg_count", {59'd0, count}, 64'd2);
    check_eq("trg_head0", {32'd0, rd_data}, 64'd10);
    check_eq("trg_ts0", {48'd0, rd_cycle}, 64'd2);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check_eq("trg_head1", {32'd0, rd_data}, 64'd12);
    check_eq("trg_ts1", {48'd0, rd_cycle}, 64'd3);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check_eq("trg_empty", {63'd0, rd_valid}, 64'd0);
`else
    // Test 1: constant 5 for 4 cycles gives a single entry stamped at cycle 0.
    sample_en = 1'b1; alu_result_in = 32'h5;
    tick();
    check_eq("t1_valid_rise", {63'd0, rd_valid}, 64'd1);
    for (int i = 0; i < 3; i++) tick();
    check_eq("t1_count", {59'd0, count}, 64'd1);
    check_eq("t1_data", {32'd0, rd_data}, 64'h5);
    check_eq("t1_cycle", {48'd0, rd_cycle}, 64'd0);
    sample_en = 1'b0; rd_en = 1'b1; tick();
    check_eq("t1_pop_count", {59'd0, count}, 64'd0);
    tick();
    rd_en = 1'b0;
    check_eq("empty_pop_ignored", {59'd0, count}, 64'd0);

    // Test 2: 1,1,2,2,3 -> entries 1,2,3 at t0, t0+2, t0+4.
    t0 = cyc_m;
    sample_en = 1'b1;
    alu_result_in = 32'd1; tick();
    alu_result_in = 32'd1; tick();
    alu_result_in = 32'd2; tick();
    alu_result_in = 32'd2; tick();
    alu_result_in = 32'd3; tick();
    sample_en = 1'b0;
    check_eq("t2_count", {59'd0, count}, 64'd3);
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_valid", {63'd0, rd_valid}, 64'd1);
      check_eq("t2_data", {32'd0, rd_data}, 64'(i + 1));
      check_eq("t2_cycle", {48'd0, rd_cycle}, 64'(t0 + 2 * i));
      check_eq("t2_ts_incr", {63'd0, (int'(rd_cycle) > prev)}, 64'd1);
      prev = int'(rd_cycle);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    check_eq("t2_drained", {63'd0, rd_valid}, 64'd0);

    // Test 3: 17 distinct values into 16 slots.
    sample_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      alu_result_in = 32'h100 + 32'(i);
      tick();
    end
    sample_en = 1'b0;
    check_eq("t3_full", {63'd0, full}, 64'd1);
    check_eq("t3_count", {59'd0, count}, 64'd16);
    check_eq("t3_ovf", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < 16; i++) begin
      check_eq("t3_drain", {32'd0, rd_data}, 64'(32'h100 + 32'(i)));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    check_eq("t3_17th_absent", {63'd0, rd_valid}, 64'd0);
    check_eq("t3_ovf_sticky", {63'd0, overflow}, 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check_eq("clr_ovf", {63'd0, overflow}, 64'd0);

    // Test 4: full FIFO with simultaneous push and pop.
    sample_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      alu_result_in = 32'h200 + 32'(i);
      tick();
    end
    check_eq("t4_full", {63'd0, full}, 64'd1);
    check_eq("t4_ovf0", {63'd0, overflow}, 64'd0);
    alu_result_in = 32'h210; rd_en = 1'b1; tick();
    sample_en = 1'b0; rd_en = 1'b0;
    check_eq("t4_count", {59'd0, count}, 64'd16);
    check_eq("t4_ovf", {63'd0, overflow}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      check_eq("t4_drain", {32'd0, rd_data}, 64'(32'h201 + 32'(i)));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    check_eq("t4_empty", {63'd0, rd_valid}, 64'd0);

    // Test 5: reset with 5 entries; first sample afterwards equals old last_value.
    sample_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_result_in = 32'h300 + 32'(i);
      tick();
    end
    sample_en = 1'b0;
    check_eq("t5_count5", {59'd0, count}, 64'd5);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("t5_count", {59'd0, count}, 64'd0);
    check_eq("t5_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("t5_ovf", {63'd0, overflow}, 64'd0);
    sample_en = 1'b1; alu_result_in = 32'h304; tick(); sample_en = 1'b0;
    check_eq("t5_recapture", {32'd0, rd_data}, 64'h304);
    check_eq("t5_ts", {48'd0, rd_cycle}, 64'd0);
    rd_en = 1'b1; tick();

    // Empty FIFO: push with rd_en performs the push only.
    sample_en = 1'b1; alu_result_in = 32'h400; tick();
    check_eq("empty_push_pop_count", {59'd0, count}, 64'd1);
    check_eq("empty_push_pop_data", {32'd0, rd_data}, 64'h400);

    // clr with push and pop in the same cycle: clr wins.
    alu_result_in = 32'h401; clr = 1'b1; tick();
    clr = 1'b0; sample_en = 1'b0; rd_en = 1'b0;
    check_eq("clr_wins_count", {59'd0, count}, 64'd0);
    check_eq("clr_wins_valid", {63'd0, rd_valid}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
